// File: rtl/mem_burst_arbiter.sv
// mem_burst_arbiter: round-robin two-requester block arbiter for a byte-wide memory port.
// Define ARB_TIMEOUT_EN to abort bursts that stall TIMEOUT cycles, pulsing err.
module mem_burst_arbiter #(
  parameter int AWIDTH = 9,
  parameter int DWIDTH = 8,
  parameter int BLOCKSIZE = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        req0,
  input  logic                        we0,
  input  logic [AWIDTH-1:0]           addr0,
  input  logic [DWIDTH*BLOCKSIZE-1:0] wblk0,
  output logic                        gnt0,
  output logic                        done0,
  output logic [DWIDTH*BLOCKSIZE-1:0] rblk0,
  input  logic                        req1,
  input  logic                        we1,
  input  logic [AWIDTH-1:0]           addr1,
  input  logic [DWIDTH*BLOCKSIZE-1:0] wblk1,
  output logic                        gnt1,
  output logic                        done1,
  output logic [DWIDTH*BLOCKSIZE-1:0] rblk1,
  output logic [AWIDTH-1:0]           mem_addr,
  output logic                        mem_rd,
  output logic                        mem_wr,
  output logic [DWIDTH-1:0]           mem_wdata,
  input  logic [DWIDTH-1:0]           mem_rdata,
  input  logic                        mem_ready,
  output logic                        err
);
  localparam int BW = DWIDTH * BLOCKSIZE;
  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;
  state_t state;
  logic last_gnt, owner, we_l, pick, xfer, unused;
  logic [AWIDTH-3:0] base;
  logic [1:0] beat;
  logic [BW-1:0] wblk_l, hold, hold_nx;
  assign unused = ^{addr0[1:0], addr1[1:0]};
  assign pick = (req0 & req1) ? ~last_gnt : req1;
  assign xfer = state == XFER;
  assign mem_rd = xfer & ~we_l;
  assign mem_wr = xfer & we_l;
  assign mem_addr = xfer ? {base, beat} : '0;
  assign mem_wdata = xfer ? wblk_l[beat*DWIDTH +: DWIDTH] : '0;
  // the final byte lands in rblk on the same edge it is captured
  always_comb begin
    hold_nx = hold;
    if (!we_l) hold_nx[beat*DWIDTH +: DWIDTH] = mem_rdata;
  end
`ifdef ARB_TIMEOUT_EN
  logic [3:0] stall;
`else
  assign err = 1'b0;
`endif
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      last_gnt <= 1'b1;
      owner <= 1'b0;
      we_l <= 1'b0;
      base <= '0;
      beat <= '0;
      wblk_l <= '0;
      hold <= '0;
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      rblk0 <= '0;
      rblk1 <= '0;
`ifdef ARB_TIMEOUT_EN
      stall <= '0;
      err <= 1'b0;
`endif
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      err <= 1'b0;
`endif
      case (state)
        IDLE: if (req0 | req1) begin
          owner <= pick;
          last_gnt <= pick;
          we_l <= pick ? we1 : we0;
          base <= pick ? addr1[AWIDTH-1:2] : addr0[AWIDTH-1:2];
          wblk_l <= pick ? wblk1 : wblk0;
          gnt0 <= ~pick;
          gnt1 <= pick;
          beat <= '0;
`ifdef ARB_TIMEOUT_EN
          stall <= '0;
`endif
          state <= XFER;
        end
        XFER: if (mem_ready) begin
          hold <= hold_nx;
`ifdef ARB_TIMEOUT_EN
          stall <= '0;
`endif
          if (beat == 2'd3) begin
            state <= DONE;
            done0 <= ~owner;
            done1 <= owner;
            if (!we_l && !owner) rblk0 <= hold_nx;
            if (!we_l && owner) rblk1 <= hold_nx;
          end else
            beat <= beat + 2'd1;
        end
`ifdef ARB_TIMEOUT_EN
        else if (stall == 4'(TIMEOUT - 1)) begin
          state <= IDLE;
          err <= 1'b1;
          done0 <= ~owner;
          done1 <= owner;
          gnt0 <= 1'b0;
          gnt1 <= 1'b0;
        end else
          stall <= stall + 4'd1;
`endif
        default: begin
          gnt0 <= 1'b0;
          gnt1 <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_burst_arbiter.sv
// tb_mem_burst_arbiter: directed scoreboard bench for mem_burst_arbiter with a byte memory model.
module tb_mem_burst_arbiter;
  logic clock = 1'b0, reset_n = 1'b0;
  logic req0 = 0, we0 = 0, req1 = 0, we1 = 0, mem_ready = 1;
  logic [8:0] addr0 = '0, addr1 = '0, mem_addr;
  logic [31:0] wblk0 = '0, wblk1 = '0, rblk0, rblk1;
  logic gnt0, gnt1, done0, done1, mem_rd, mem_wr, err;
  logic [7:0] mem_wdata, mem_rdata;
  logic [7:0] mem [0:511];
  typedef struct {logic who; logic [31:0] blk;} exp_t;
  exp_t sb[$];
  int total = 0, bad = 0;
  logic done_seen;
  logic [31:0] rblk0_m = '0, rblk1_m = '0;

  mem_burst_arbiter dut (
    .clock(clock), .reset_n(reset_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wblk0(wblk0), .gnt0(gnt0), .done0(done0), .rblk0(rblk0),
    .req1(req1), .we1(we1), .addr1(addr1), .wblk1(wblk1), .gnt1(gnt1), .done1(done1), .rblk1(rblk1),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .err(err)
  );

  always #5 clock = ~clock;
  assign mem_rdata = mem[mem_addr];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    exp_t e;
    if (mem_wr && mem_ready) mem[mem_addr] = mem_wdata;
    @(posedge clock);
    #1;
    chk("gnt_excl", gnt0 & gnt1, 0);
    chk("strobe_excl", mem_rd & mem_wr, 0);
`ifndef ARB_TIMEOUT_EN
    chk("err_zero", err, 0);
`endif
    if (done0 | done1) begin
      done_seen = 1;
      if (sb.size() == 0) chk("done_unexpected", {done1, done0}, 0);
      else begin
        e = sb.pop_front();
        chk("done_who", {done1, done0}, e.who ? 2'b10 : 2'b01);
        chk("rblk", e.who ? rblk1 : rblk0, e.blk);
      end
    end
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    done_seen = 0;
    while (!done_seen && n < budget) begin
      tick();
      n++;
    end
    chk("done_wait", done_seen, 1);
  endtask

  task automatic do_reset();
    reset_n = 0;
    rblk0_m = '0;
    rblk1_m = '0;
    #1;
    chk("rst_outs", {gnt0, gnt1, done0, done1, mem_rd, mem_wr, err}, 0);
    chk("rst_addr", {mem_addr, mem_wdata}, 0);
    chk("rst_rblk", {rblk1, rblk0}, 0);
    tick();
    tick();
    reset_n = 1;
  endtask

  initial begin
    int pat[7] = '{1, 0, 0, 1, 0, 1, 1};
    int beats;
    for (int i = 0; i < 512; i++) mem[i] = 8'(i * 7 + 3);
    {mem[9'h0A7], mem[9'h0A6], mem[9'h0A5], mem[9'h0A4]} = 32'h44332211;
    {mem[9'h013], mem[9'h012], mem[9'h011], mem[9'h010]} = 32'h5A6B7C8D;
    {mem[9'h0B3], mem[9'h0B2], mem[9'h0B1], mem[9'h0B0]} = 32'hD4C3B2A1;
    #2;
    do_reset();
    tick();
    // read by requester 0, no stalls
    req0 = 1; we0 = 0; addr0 = 9'h0A7;
    rblk0_m = 32'h44332211;
    sb.push_back('{1'b0, rblk0_m});
    tick();
    chk("rd_gnt0", {gnt1, gnt0}, 2'b01);
    chk("rd_addr0", mem_addr, 9'h0A4);
    chk("rd_strobe", {mem_wr, mem_rd}, 2'b01);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk("rd_addr", mem_addr, 9'h0A4 + 9'(i));
    end
    done_seen = 0;
    tick();
    chk("rd_done_cycle", done_seen, 1);
    chk("done_strobes", {mem_wr, mem_rd}, 0);
    req0 = 0;
    tick();
    chk("idle_gnt", {gnt1, gnt0}, 0);
    // write by requester 1
    req1 = 1; we1 = 1; addr1 = 9'h120; wblk1 = 32'hDEADBEEF;
    sb.push_back('{1'b1, rblk1_m});
    tick();
    chk("wr_gnt1", {gnt1, gnt0}, 2'b10);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      chk("wr_strobe", {mem_wr, mem_rd}, 2'b10);
      chk("wr_addr", mem_addr, 9'h120 + 9'(i));
      chk("wr_data", mem_wdata, 8'(32'hDEADBEEF >> (8 * i)));
    end
    wait_done(3);
    req1 = 0;
    chk("wr_mem", {mem[9'h123], mem[9'h122], mem[9'h121], mem[9'h120]}, 32'hDEADBEEF);
    tick();
    // round robin from reset
    do_reset();
    req0 = 1; we0 = 0; addr0 = 9'h012;
    req1 = 1; we1 = 1; addr1 = 9'h041; wblk1 = 32'h01020304;
    rblk0_m = 32'h5A6B7C8D;
    sb.push_back('{1'b0, rblk0_m});
    sb.push_back('{1'b1, rblk1_m});
    sb.push_back('{1'b0, rblk0_m});
    wait_done(20);
    wait_done(20);
    wait_done(20);
    req0 = 0; req1 = 0;
    chk("rr_sb_empty", sb.size(), 0);
    chk("rr_mem", {mem[9'h043], mem[9'h042], mem[9'h041], mem[9'h040]}, 32'h01020304);
    tick();
    // stalls during a read
    req0 = 1; addr0 = 9'h0B0;
    rblk0_m = 32'hD4C3B2A1;
    sb.push_back('{1'b0, rblk0_m});
    tick();
    beats = 0;
    done_seen = 0;
    for (int i = 0; i < 7; i++) begin
      mem_ready = pat[i][0];
      chk("stall_addr", mem_addr, 9'h0B0 + 9'(beats));
      tick();
      beats += pat[i];
    end
    chk("stall_done", done_seen, 1);
    mem_ready = 1;
    req0 = 0;
    tick();
    // reset in the middle of a read
    req0 = 1; addr0 = 9'h0A4;
    repeat (4) tick();
    chk("mid_addr", mem_addr, 9'h0A7);
    req0 = 0;
    reset_n = 0;
    rblk0_m = '0;
    rblk1_m = '0;
    #1;
    chk("mid_rst_outs", {gnt0, gnt1, done0, done1, mem_rd, mem_wr, err}, 0);
    chk("mid_rst_addr", mem_addr, 0);
    chk("mid_rst_rblk", rblk0, 0);
    done_seen = 0;
    repeat (2) tick();
    chk("mid_no_done", done_seen, 0);
    reset_n = 1;
    req1 = 1; we1 = 0; addr1 = 9'h0A6;
    rblk1_m = 32'h44332211;
    sb.push_back('{1'b1, rblk1_m});
    tick();
    chk("post_rst_gnt1", {gnt1, gnt0}, 2'b10);
    wait_done(10);
    req1 = 0;
    tick();
    // long stall: abort with the timeout feature, otherwise wait it out
    req0 = 1; addr0 = 9'h0B0;
    tick();
    mem_ready = 0;
`ifdef ARB_TIMEOUT_EN
    sb.push_back('{1'b0, rblk0_m});
    done_seen = 0;
    repeat (14) tick();
    chk("to_early", {done_seen, err}, 0);
    tick();
    chk("to_err", {err, done0}, 2'b11);
    req0 = 0;
    mem_ready = 1;
    tick();
    chk("to_idle", {gnt0, mem_rd, err}, 0);
`else
    repeat (20) tick();
    chk("hang_gnt", gnt0, 1);
    chk("hang_addr", mem_addr, 9'h0B0);
    rblk0_m = 32'hD4C3B2A1;
    sb.push_back('{1'b0, rblk0_m});
    mem_ready = 1;
    wait_done(6);
    req0 = 0;
    tick();
`endif
    chk("end_sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_burst_arbiter.md
Name: mem_burst_arbiter

Overview:
- Shares the single byte-wide main-memory port between two cache controllers, for example an instruction cache and a data cache of the 2-way set-associative type.
- Each requester issues one whole-block operation: block read (refill) or block write (writeback) of BLOCKSIZE bytes.
- The arbiter grants requesters round-robin, sequences the byte-serial burst against mem_ready, and returns the assembled block with a one-cycle done pulse.

Parameters:
- AWIDTH, 9, byte address width.
- DWIDTH, 8, memory data width (one byte).
- BLOCKSIZE, 4, bytes per block; fixed at 4 (2-bit beat counter).
- TIMEOUT, 15, stall limit in cycles; used only with ARB_TIMEOUT_EN.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req0  in  1  requester 0 block request; held high until done0.
- we0  in  1  requester 0 op: 1 = block write, 0 = block read.
- addr0  in  AWIDTH  requester 0 block address; bits [1:0] ignored.
- wblk0  in  DWIDTH*BLOCKSIZE  requester 0 write block; byte 0 in [7:0].
- gnt0  out  1  requester 0 owns the memory port.
- done0  out  1  one-cycle pulse: requester 0 operation complete.
- rblk0  out  DWIDTH*BLOCKSIZE  requester 0 read block; valid when done0 is high, held until the next requester 0 read completes.
- req1, we1, addr1, wblk1, gnt1, done1, rblk1: same as above, for requester 1.
- mem_addr  out  AWIDTH  memory byte address.
- mem_rd  out  1  memory read strobe.
- mem_wr  out  1  memory write strobe.
- mem_wdata  out  DWIDTH  memory write byte.
- mem_rdata  in  DWIDTH  memory read byte.
- mem_ready  in  1  memory accepts/returns the current beat this cycle.
- err  out  1  one-cycle pulse on timeout abort; tied 0 when ARB_TIMEOUT_EN is undefined.

Behaviour:
- Reset values: all outputs 0; state IDLE; last_gnt = 1, so requester 0 wins the first tie.
- States: IDLE, XFER, DONE.
- IDLE:
  - Only req0 high: grant 0. Only req1 high: grant 1.
  - Both high: grant the requester that is not last_gnt.
  - On grant: latch base address {addrX[AWIDTH-1:2],2'b00}, weX and wblkX into internal registers; set gntX and last_gnt; beat = 0; go to XFER.
  - gntX rises the cycle after the request is sampled.
- XFER:
  - mem_rd = ~we_l and mem_wr = we_l, driven continuously.
  - mem_addr = {base[AWIDTH-1:2], beat}.
  - mem_wdata = byte[beat] of the latched block.
- Beat completion: a beat completes on a cycle with mem_ready = 1. On a read, mem_rdata is captured into byte lane [beat] of the holding register.
- Beat sequencing: if beat == 3 on completion, go to DONE; otherwise beat increments. A burst with mem_ready held high takes exactly 4 XFER cycles.
- DONE (one cycle):
  - mem_rd and mem_wr are 0; doneX pulses.
  - rblkX is updated from the holding register on reads only.
  - gntX drops; go to IDLE.
  - A new grant can be issued on the cycle after DONE (minimum 1 IDLE cycle between bursts).
- Request changes mid-burst: a req falling mid-burst is ignored and the burst completes. The latched addr/we/wblk are unaffected by input changes during the burst.
- A requester still asserting req after its done is treated as a new request.
- Only one of gnt0/gnt1 is ever high; mem_rd and mem_wr are never both high.
- Reset mid-burst: immediate return to reset values; the partial block is discarded; no done pulse.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A 4-bit stall counter counts consecutive XFER cycles with mem_ready = 0, cleared on any beat completion.
  - When the counter reaches TIMEOUT: abort the burst, pulse err and the granted doneX together, leave rblkX unchanged, drop strobes and gnt, go to IDLE.
  - last_gnt still updates.
- Undefined: no counter; XFER waits indefinitely for mem_ready; err is constant 0.

Test Plan:
- Read, requester 0: req0=1, we0=0, addr0=9'h0A7, mem_ready held 1, memory returns 11,22,33,44 -> gnt0 next cycle; mem_addr 0A4,0A5,0A6,0A7 on consecutive cycles; done0 pulse; rblk0 = 32'h44332211.
- Write, requester 1: req1=1, we1=1, addr1=9'h120, wblk1=32'hDEADBEEF -> mem_wr for 4 beats; mem_wdata EF,BE,AD,DE; done1 pulse; rblk1 unchanged.
- Round-robin: req0 and req1 both held high for 3 bursts from reset -> grant order 0,1,0; gnt0 and gnt1 never high together.
- Stalls: mem_ready toggles 1,0,0,1,0,1,1 during a read -> exactly 4 bytes captured, in the correct lanes; mem_addr holds during stall cycles.
- Reset mid-burst: reset_n low after beat 2 of a read -> all outputs 0 immediately; no done; next req1 is granted normally.
- Timeout (ARB_TIMEOUT_EN defined): mem_ready=0 for 15 cycles in XFER -> err and done0 pulse together; rblk0 unchanged; state returns to IDLE.
